// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard scoreboard.
//   FWD_RF / FWD_EX / FWD_MEM : forward-select encodings driven on fwd_a / fwd_b
//   BUBBLE_IR                 : instruction word the ID stage substitutes when bubble is high
//   reg_addr_t                : architectural register address for the default 5-bit build
package pipe_pkg;

  localparam int          AW_DEF    = 5;
  localparam logic [1:0]  FWD_RF    = 2'd0;
  localparam logic [1:0]  FWD_EX    = 2'd1;
  localparam logic [1:0]  FWD_MEM   = 2'd2;
  localparam logic [31:0] BUBBLE_IR = 32'hFFFF_FFFF;

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/pipe_hazard_scoreboard_sb_entry.sv
// sb_entry: scoreboard slot for one architectural register.
//   clk, rst : clock and synchronous active-low reset
//   set      : an instruction writing this register issues (wins over clr/decrement)
//   set_ld   : that instruction is a load
//   clr      : register-file write to this register this cycle
//   cnt      : cycles remaining until the in-flight write lands (0 = idle)
//   ld       : the in-flight writer is a load (kept only when
//              PIPE_HAZARD_SCOREBOARD_FWD_EN is defined, otherwise tied 0)
module sb_entry
  import pipe_pkg::*;
#(
  parameter int WB_LAT = 3,
  parameter int CW     = $clog2(WB_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic          set_ld,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          ld
);

  localparam logic [CW-1:0] LAT_C  = CW'(WB_LAT);
  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Countdown: a new issue reloads, a write-back clears, otherwise count toward zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= ZERO_C;
    end else if (set) begin
      cnt_r <= LAT_C;
    end else if (clr) begin
      cnt_r <= ZERO_C;
    end else if (cnt_r != ZERO_C) begin
      cnt_r <= cnt_r - ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

`ifdef PIPE_HAZARD_SCOREBOARD_FWD_EN
  logic ld_r;

  // Load flag follows the most recent issuing writer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_r <= 1'b0;
    end else if (set) begin
      ld_r <= set_ld;
    end else begin
      ld_r <= ld_r;
    end
  end

  assign ld = ld_r;
`else
  logic unused_s;
  assign unused_s = set_ld;
  assign ld       = 1'b0;
`endif

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: RAW-hazard stall and branch-flush control for the
// 5-stage pipeline, using a per-register countdown of in-flight writes.
// Optional feature macro: PIPE_HAZARD_SCOREBOARD_FWD_EN (EX/MEM forwarding,
// only load-use stalls).
//   clk, rst              : clock, synchronous active-low reset
//   id_valid              : ID holds a real instruction
//   id_rs_en/id_rs        : rs read enable / address
//   id_rt_en/id_rt        : rt read enable / address
//   id_wr_en/id_rd        : rd write enable / address
//   id_is_load            : instruction is a load (used with forwarding only)
//   wb_en/wb_addr         : register-file write this cycle
//   br_taken              : EX resolved a taken branch
//   stall, bubble, flush  : IF hold, ID bubble-insert select, IF/ID squash
//   issue                 : ID instruction accepted into EX
//   fwd_a, fwd_b          : rs / rt forward select (RF / EX / MEM)
module pipe_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int WB_LAT   = 3,
  parameter int BR_FLUSH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          id_rs_en,
  input  logic [AW-1:0] id_rs,
  input  logic          id_rt_en,
  input  logic [AW-1:0] id_rt,
  input  logic          id_wr_en,
  input  logic [AW-1:0] id_rd,
  input  logic          id_is_load,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic          br_taken,
  output logic          stall,
  output logic          bubble,
  output logic          flush,
  output logic          issue,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b
);

  localparam int          CW      = $clog2(WB_LAT + 1);
  localparam int          NSLOT   = 2 ** AW;
  localparam logic [2:0]  FL_LOAD = 3'(BR_FLUSH - 1);
  localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};

  // Slots for r0 and for addresses >= NREG read as permanently idle, so any
  // address can index the table without a separate range check.
  logic [CW-1:0]    cnt_s [NSLOT];
  logic [NSLOT-1:0] ld_s;
  logic [2:0]       fcnt_r;

  logic rs_chk_s, rt_chk_s, pend_rs_s, pend_rt_s;
  logic flush_s, stall_s, issue_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  for (genvar r = 0; r < NSLOT; r++) begin : g_sb
    if (r == 0 || r >= NREG) begin : g_none
      assign cnt_s[r] = CW'(0);
      assign ld_s[r]  = 1'b0;
    end else begin : g_ent
      sb_entry #(.WB_LAT(WB_LAT), .CW(CW)) u_entry (
        .clk    (clk),
        .rst    (rst),
        .set    (issue_s && id_wr_en && (id_rd == AW'(r))),
        .set_ld (id_is_load),
        .clr    (wb_en && (wb_addr == AW'(r))),
        .cnt    (cnt_s[r]),
        .ld     (ld_s[r])
      );
    end
  end

  // Flush counter: a taken branch (re)loads, otherwise count down to idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fcnt_r <= 3'd0;
    end else if (br_taken) begin
      fcnt_r <= FL_LOAD;
    end else if (fcnt_r != 3'd0) begin
      fcnt_r <= fcnt_r - 3'd1;
    end else begin
      fcnt_r <= fcnt_r;
    end
  end

`ifdef PIPE_HAZARD_SCOREBOARD_FWD_EN
  localparam logic [CW-1:0] LAT_C    = CW'(WB_LAT);
  localparam logic [CW-1:0] LAT_M1_C = CW'(WB_LAT - 1);

  // With forwarding only a load still in EX blocks; younger results are bypassed.
  always_comb begin
    rs_chk_s  = id_rs_en && (id_rs != ZERO_A);
    rt_chk_s  = id_rt_en && (id_rt != ZERO_A);
    pend_rs_s = rs_chk_s && (cnt_s[id_rs] == LAT_C) && ld_s[id_rs];
    pend_rt_s = rt_chk_s && (cnt_s[id_rt] == LAT_C) && ld_s[id_rt];
    fwd_a_s   = FWD_RF;
    fwd_b_s   = FWD_RF;
    if (rs_chk_s && (cnt_s[id_rs] == LAT_C)) begin
      fwd_a_s = FWD_EX;
    end else if (rs_chk_s && (LAT_M1_C != CW'(0)) && (cnt_s[id_rs] == LAT_M1_C)) begin
      fwd_a_s = FWD_MEM;
    end else begin
      fwd_a_s = FWD_RF;
    end
    if (rt_chk_s && (cnt_s[id_rt] == LAT_C)) begin
      fwd_b_s = FWD_EX;
    end else if (rt_chk_s && (LAT_M1_C != CW'(0)) && (cnt_s[id_rt] == LAT_M1_C)) begin
      fwd_b_s = FWD_MEM;
    end else begin
      fwd_b_s = FWD_RF;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^ld_s;

  // Without forwarding any outstanding write to a source register blocks.
  always_comb begin
    rs_chk_s  = id_rs_en && (id_rs != ZERO_A);
    rt_chk_s  = id_rt_en && (id_rt != ZERO_A);
    pend_rs_s = rs_chk_s && (cnt_s[id_rs] != CW'(0));
    pend_rt_s = rt_chk_s && (cnt_s[id_rt] != CW'(0));
    fwd_a_s   = FWD_RF;
    fwd_b_s   = FWD_RF;
  end
`endif

  // Control: a flush overrides a stall, and either one blocks issue.
  always_comb begin
    flush_s = br_taken || (fcnt_r != 3'd0);
    stall_s = id_valid && (pend_rs_s || pend_rt_s) && !flush_s;
    issue_s = id_valid && !stall_s && !flush_s;
  end

  assign stall  = stall_s;
  assign flush  = flush_s;
  assign bubble = stall_s || flush_s;
  assign issue  = issue_s;
  assign fwd_a  = fwd_a_s;
  assign fwd_b  = fwd_b_s;

endmodule
